fun_sched: RTL and testbench
============================

Name: fun_sched

Overview:
Round-robin scheduler that shares one fun core (result = a * cbrt(b), 11-bit) among N requesting clients. It arbitrates requests, latches the winner's operands and drives them to the core. It issues the core's start pulse, waits for the core's busy to fall, then returns the result to the winning client with a done pulse. A watchdog flags a core that never finishes.

Parameters:
N, 4, number of requesting clients (2..8)
TIMEOUT, 64, max cycles in WAIT with fun_busy high before err is raised (>= 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_i  in  N  per-client request level; held with operands until ack_o seen
a_i  in  8*N  client k operand a at [8k+7:8k]
b_i  in  8*N  client k operand b at [8k+7:8k]
ack_o  out  N  one-hot 1-cycle pulse, request accepted, operands captured
done_o  out  N  one-hot 1-cycle pulse, result_o/err_o valid for that client
result_o  out  11  result for the client flagged by done_o
err_o  out  1  1-cycle pulse with done_o when the job timed out
fun_start  out  1  start pulse to the fun core
fun_a  out  8  latched operand a to the core
fun_b  out  8  latched operand b to the core
fun_busy  in  1  core busy (combinational, high from cycle after start to completion)
fun_result  in  11  core result register, valid when busy falls

Behaviour:
- Reset values: ack_o=0, done_o=0, result_o=0, err_o=0, fun_start=0, fun_a=0, fun_b=0, state=IDLE, rr pointer=0, grant index=0, watchdog=0. Reset mid-job aborts with no done_o; the core shares rst.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - If any req_i is set and fun_busy=0, pick the winner: first set bit scanning from rr pointer upward, with wrap-around.
  - On that edge: latch the winner's a/b into fun_a/fun_b, store the grant index, go to ISSUE.
  - No requests, or fun_busy=1: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - fun_start=1 and ack_o[grant]=1.
  - rr pointer <= grant+1, wrapping at N.
  - Clear watchdog; go to WAIT.
- WAIT:
  - fun_a/fun_b are held stable.
  - If fun_busy=0, capture fun_result into result_o and go to DONE.
  - Otherwise increment the watchdog.
  - When the watchdog reaches TIMEOUT-1 with fun_busy still 1: result_o <= 0, set a pending err flag, go to DONE.
- DONE (exactly 1 cycle):
  - done_o[grant]=1 and err_o=pending err.
  - Next state: DRAIN if err was set, else IDLE.
  - result_o holds its value until the next done.
- DRAIN:
  - Wait for fun_busy=0, then go to IDLE.
  - No new start is issued while the core is busy.
- Requests arriving outside IDLE are ignored (not queued). Clients must keep req_i high.
- Clients drop req_i the cycle after ack_o. A req_i still high in IDLE after DONE counts as a new job.
- Simultaneous requests are resolved by the rr pointer only. There is no starvation: each client waits at most N-1 jobs.
- Latency from req in IDLE: ack/start at +1. done_o arrives 1 cycle after the first cycle in WAIT with fun_busy=0, i.e. core latency + 3 cycles total.
- fun_start is never asserted while fun_busy=1.

Test Plan:
- Client 0 only, a=3, b=27 → ack_o=0001 one cycle after req, then done_o=0001 with result_o=9, err_o=0; fun_start high exactly 1 cycle.
- Client 2, a=255, b=255 (cbrt=6) → result_o=1530. Then client 1, a=10, b=8 → 20. Then client 3, b=0 → 0.
- All four request together after reset, operands a=k+1, b=8 → grant order 0,1,2,3; results 2,4,6,8. Then clients 1 and 3 together → order 1 then 3 (pointer continues from 0 after client 3 was last served).
- Client 0 re-requests immediately after each done while client 1 requests continuously → grants alternate 0,1,0,1; no client starves.
- Stub core holding fun_busy=1 for 100 cycles, TIMEOUT=64 → done_o and err_o pulse together 64 cycles into WAIT with result_o=0. No fun_start occurs until the stub's busy falls, then the next request is served normally.
- Assert rst during WAIT → all outputs 0 immediately, no done_o; after release, a fresh request from client 3 is served first (pointer reset to 0, only requester).

Source files
------------

// File: rtl/fun_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : fun_sched_if
// Brief    : Client request/response bundle plus fun-core link for fun_sched.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface fun_sched_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_i;
    logic [8*N-1:0] a_i;
    logic [8*N-1:0] b_i;
    logic [N-1:0]   ack_o;
    logic [N-1:0]   done_o;
    logic [10:0]    result_o;
    logic           err_o;
    logic           fun_start;
    logic [7:0]     fun_a;
    logic [7:0]     fun_b;
    logic           fun_busy;
    logic [10:0]    fun_result;

    modport slave (
        input  req_i, a_i, b_i, fun_busy, fun_result,
        output ack_o, done_o, result_o, err_o, fun_start, fun_a, fun_b
    );

    modport master (
        output req_i, a_i, b_i, fun_busy, fun_result,
        input  ack_o, done_o, result_o, err_o, fun_start, fun_a, fun_b
    );
endinterface
`default_nettype wire

// File: rtl/fun_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : fun_sched
// Brief    : Round-robin scheduler sharing one fun core among N clients.
// Revision : 1.0
// ---------------------------------------------------------------------------
module fun_sched #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fun_sched_if.slave  bus
);
    localparam int             IW       = $clog2(N);
    localparam int             WW       = $clog2(TIMEOUT);
    localparam logic [WW-1:0]  WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_pend_q, err_pend_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  done_q, done_d;
    logic [10:0]   result_q, result_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic [7:0]    fa_q, fa_d;
    logic [7:0]    fb_q, fb_d;

    logic [IW-1:0] w_winner;
    logic          w_found;
    logic [N-1:0]  w_rot;
    logic [IW:0]   w_sum;

    // Rotate requests so bit 0 is the client at the rr pointer, then take the first set bit.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_rot    = N'({bus.req_i, bus.req_i} >> rr_q);
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, rr_q} + (IW+1)'(i);
                if (w_sum >= (IW+1)'(N)) begin
                    w_sum = w_sum - (IW+1)'(N);
                end
                w_winner = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        wd_d       = wd_q;
        err_pend_d = err_pend_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        start_d    = 1'b0;
        result_d   = result_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        case (state_q)
            S_IDLE: begin
                if (w_found && !bus.fun_busy) begin
                    fa_d             = bus.a_i[{w_winner, 3'b000} +: 8];
                    fb_d             = bus.b_i[{w_winner, 3'b000} +: 8];
                    grant_d          = w_winner;
                    ack_d[w_winner]  = 1'b1;
                    start_d          = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rr_d       = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                wd_d       = '0;
                err_pend_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.fun_busy) begin
                    result_d        = bus.fun_result;
                    done_d[grant_q] = 1'b1;
                    state_d         = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    result_d        = '0;
                    err_pend_d      = 1'b1;
                    done_d[grant_q] = 1'b1;
                    err_d           = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                // A timed-out core may still be busy; hold off new starts until it drains.
                state_d = err_pend_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.fun_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            grant_q    <= '0;
            wd_q       <= '0;
            err_pend_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            fa_q       <= '0;
            fb_q       <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            wd_q       <= wd_d;
            err_pend_q <= err_pend_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_q      <= err_d;
            start_q    <= start_d;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.done_o    = done_q;
    assign bus.result_o  = result_q;
    assign bus.err_o     = err_q;
    assign bus.fun_start = start_q;
    assign bus.fun_a     = fa_q;
    assign bus.fun_b     = fb_q;
endmodule
`default_nettype wire

// File: tb/tb_fun_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_fun_sched
// Brief    : Directed scoreboard bench for fun_sched with a behavioural fun core.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_fun_sched;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fun_sched_if #(.N(N)) bus ();

    fun_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int icbrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Behavioural core: busy for core_lat cycles after the start edge.
    int          core_lat = 3;
    int          core_cnt;
    logic [10:0] core_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt <= 0;
            core_res <= '0;
        end else if (bus.fun_start) begin
            core_cnt <= core_lat;
            core_res <= 11'(int'(bus.fun_a) * icbrt(int'(bus.fun_b)));
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign bus.fun_busy   = (core_cnt != 0);
    assign bus.fun_result = core_res;

    typedef struct {
        int          client;
        logic [10:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           first_ack_cyc, start_cnt, last_start_cyc, last_done_cyc, s1;
    logic [N-1:0] hold_mask = '0;
    bit           rereq0    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic push(input int c, input int r, input bit e);
        sb.push_back('{c, 11'(r), e});
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        bus.a_i[8*k +: 8] = 8'(a);
        bus.b_i[8*k +: 8] = 8'(b);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(bus.ack_o),     0);
        check({tag, "_done"},   32'(bus.done_o),    0);
        check({tag, "_result"}, 32'(bus.result_o),  0);
        check({tag, "_err"},    32'(bus.err_o),     0);
        check({tag, "_start"},  32'(bus.fun_start), 0);
        check({tag, "_fun_a"},  32'(bus.fun_a),     0);
        check({tag, "_fun_b"},  32'(bus.fun_b),     0);
    endtask

    // Drives client handshakes and pops the scoreboard on every done_o.
    task automatic run(input int n_want, input int budget);
        int   got = 0;
        int   c   = 0;
        exp_t e;
        first_ack_cyc = -1;
        start_cnt     = 0;
        while (got < n_want && c < budget) begin
            @(negedge clk);
            c++;
            cyc++;
            if (bus.fun_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                check("start_while_busy", 32'(bus.fun_busy), 0);
            end
            if (bus.ack_o != '0) begin
                if (first_ack_cyc < 0) first_ack_cyc = c;
                bus.req_i = bus.req_i & ~(bus.ack_o & ~hold_mask);
            end
            if (bus.done_o != '0) begin
                last_done_cyc = cyc;
                got++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.done_o), 0);
                end else begin
                    e = sb.pop_front();
                    check("done_client", 32'(bus.done_o), 32'(1) << e.client);
                    check("done_result", 32'(bus.result_o), 32'(e.res));
                    check("done_err",    32'(bus.err_o),    32'(e.err));
                end
                if (rereq0) bus.req_i[0] = 1'b1;
            end
        end
        check("jobs_completed", got, n_want);
    endtask

    initial begin
        int w;
        bus.req_i = '0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        rst       = 1'b1;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Single client, check latency and single-cycle start.
        set_ops(0, 3, 27);
        push(0, 9, 0);
        bus.req_i = 4'b0001;
        run(1, 20);
        check("t1_ack_latency",  first_ack_cyc, 1);
        check("t1_start_cycles", start_cnt, 1);
        check("t1_done_latency", last_done_cyc - last_start_cyc, core_lat + 2);
        check("t1_fun_a",        32'(bus.fun_a), 3);
        check("t1_fun_b",        32'(bus.fun_b), 27);

        // Individual clients with assorted operands.
        set_ops(2, 255, 255); push(2, 1530, 0); bus.req_i = 4'b0100; run(1, 20);
        set_ops(1, 10, 8);    push(1, 20, 0);   bus.req_i = 4'b0010; run(1, 20);
        set_ops(3, 77, 0);    push(3, 0, 0);    bus.req_i = 4'b1000; run(1, 20);

        // Simultaneous requests from a fresh pointer.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        for (int k = 0; k < N; k++) begin
            set_ops(k, k + 1, 8);
            push(k, 2 * (k + 1), 0);
        end
        bus.req_i = 4'b1111;
        run(4, 60);
        set_ops(1, 10, 27); set_ops(3, 6, 64);
        push(1, 30, 0); push(3, 24, 0);
        bus.req_i = 4'b1010;
        run(2, 40);

        // Fairness: client 1 holds its request, client 0 re-requests after every done.
        set_ops(0, 5, 64); set_ops(1, 7, 125);
        push(0, 20, 0); push(1, 35, 0); push(0, 20, 0); push(1, 35, 0);
        hold_mask = 4'b0010;
        rereq0    = 1'b1;
        bus.req_i = 4'b0011;
        run(4, 80);
        rereq0    = 1'b0;
        hold_mask = '0;
        bus.req_i = '0;
        tick(3);

        // Hung core: watchdog fires, then no start until the core drains.
        core_lat = 100;
        set_ops(0, 9, 27);
        push(0, 0, 1);
        bus.req_i = 4'b0001;
        run(1, 200);
        check("t5_timeout_cycles", last_done_cyc - last_start_cyc, TIMEOUT + 1);
        s1       = last_start_cyc;
        core_lat = 3;
        set_ops(1, 2, 1);
        push(1, 2, 0);
        bus.req_i = 4'b0010;
        run(1, 200);
        check("t5_start_count",      start_cnt, 1);
        check("t5_start_after_busy", 32'(last_start_cyc - s1 > 100), 1);

        // Reset in the middle of a job.
        core_lat = 20;
        set_ops(2, 4, 8);
        bus.req_i = 4'b0100;
        w = 0;
        while (bus.ack_o == '0 && w < 10) begin
            @(negedge clk);
            cyc++;
            w++;
        end
        check("t6_ack_seen", 32'(bus.ack_o), 32'h4);
        bus.req_i = '0;
        tick(3);
        rst = 1'b1;
        #1;
        check_all_zero("t6_midreset");
        tick(2);
        rst      = 1'b0;
        core_lat = 3;
        set_ops(3, 3, 8);
        push(3, 6, 0);
        bus.req_i = 4'b1000;
        run(1, 30);
        check("t6_ack_latency", first_ack_cyc, 1);
        check("t6_sb_empty",    sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
